conv_seq: RTL and testbench

- Sequencer for the `conv` convolution datapath.
- On `start`, fetches the image and kernel from two synchronous-read buffers and streams them into `conv` in `conv`'s native beat format.
- Waits out the compute interval, then captures the serial result stream and presents it with a valid strobe.
- Sits between the buffer/loader logic and the `conv` instance, replacing bench-driven stimulus.

---
 rtl/conv_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_conv_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq.sv
// conv_seq: fetches image and kernel from synchronous-read buffers, streams them into conv in
// row-major beats with a zero delimiter per row, waits out compute and forwards the results.
module conv_seq #(
  parameter int unsigned DW         = 8,
  parameter int unsigned OW         = 16,
  parameter int unsigned DIMW       = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIMW-1:0]   in_row,
  input  logic [DIMW-1:0]   in_col,
  input  logic [DIMW-1:0]   ker_row,
  input  logic [DIMW-1:0]   ker_col,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              img_rd,
  output logic [2*DIMW-1:0] img_addr,
  input  logic [DW-1:0]     img_rdata,
  output logic              ker_rd,
  output logic [2*DIMW-1:0] ker_addr,
  input  logic [DW-1:0]     ker_rdata,
  output logic [DW-1:0]     conv_in_matrix,
  output logic [DW-1:0]     conv_kernel,
  output logic [DIMW-1:0]   conv_in_row,
  output logic [DIMW-1:0]   conv_in_col,
  output logic [DIMW-1:0]   conv_ker_row,
  output logic [DIMW-1:0]   conv_ker_col,
  input  logic [OW-1:0]     conv_out,
  output logic              res_valid,
  output logic [OW-1:0]     res_data,
  output logic [DIMW-1:0]   res_row,
  output logic [DIMW-1:0]   res_col
);

  localparam int unsigned    SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [DIMW-1:0] One = DIMW'(1);

  typedef enum logic [2:0] {StIdle, StLdImg, StLdKer, StSettle, StCompute, StDrain} state_e;

  state_e          state_q, state_d;
  logic [DIMW-1:0] row_q, row_d, col_q, col_d, k_q, k_d, l_q, l_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            done_q, done_d, cfg_err_q, cfg_err_d;
  // *_beat_q: a beat was issued last cycle; *_fetch_q: that beat read the buffer (else delimiter)
  logic            img_beat_q, img_beat_d, img_fetch_q, img_fetch_d;
  logic            ker_beat_q, ker_beat_d, ker_fetch_q, ker_fetch_d;
  logic            latch;
  logic            cfg_bad;
  logic [DIMW-1:0] out_rows, out_cols;

  assign cfg_bad = (in_row == '0) || (in_col == '0) || (ker_row == '0) || (ker_col == '0) ||
                   (ker_row > in_row) || (ker_col > in_col);
  assign out_rows = conv_in_row - conv_ker_row + One;
  assign out_cols = conv_in_col - conv_ker_col + One;

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      row_q          <= '0;
      col_q          <= '0;
      k_q            <= '0;
      l_q            <= '0;
      settle_q       <= '0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
      img_beat_q     <= 1'b0;
      img_fetch_q    <= 1'b0;
      ker_beat_q     <= 1'b0;
      ker_fetch_q    <= 1'b0;
      conv_in_matrix <= '0;
      conv_kernel    <= '0;
      conv_in_row    <= '0;
      conv_in_col    <= '0;
      conv_ker_row   <= '0;
      conv_ker_col   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      k_q         <= k_d;
      l_q         <= l_d;
      settle_q    <= settle_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      img_beat_q  <= img_beat_d;
      img_fetch_q <= img_fetch_d;
      ker_beat_q  <= ker_beat_d;
      ker_fetch_q <= ker_fetch_d;
      if (latch) begin
        conv_in_row  <= in_row;
        conv_in_col  <= in_col;
        conv_ker_row <= ker_row;
        conv_ker_col <= ker_col;
      end
      if (img_beat_q) conv_in_matrix <= img_fetch_q ? img_rdata : '0;
      if (ker_beat_q) conv_kernel <= ker_fetch_q ? ker_rdata : '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    k_d         = k_q;
    l_d         = l_q;
    settle_d    = settle_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    img_beat_d  = 1'b0;
    img_fetch_d = 1'b0;
    ker_beat_d  = 1'b0;
    ker_fetch_d = 1'b0;
    latch       = 1'b0;
    img_rd      = 1'b0;
    img_addr    = '0;
    ker_rd      = 1'b0;
    ker_addr    = '0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_row     = '0;
    res_col     = '0;

    unique case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          if (cfg_bad) begin
            done_d    = 1'b1;
            cfg_err_d = 1'b1;
          end else begin
            latch   = 1'b1;
            state_d = StLdImg;
            row_d   = '0;
            col_d   = '0;
            k_d     = '0;
            l_d     = '0;
          end
        end
      end
      StLdImg: begin
        img_beat_d = 1'b1;
        if (col_q != conv_in_col) begin
          img_rd      = 1'b1;
          img_addr    = {row_q, col_q};
          img_fetch_d = 1'b1;
          col_d       = col_q + One;
        end else begin
          col_d = '0;
          row_d = row_q + One;
          if (row_q == conv_in_row - One) begin
            row_d   = '0;
            state_d = StLdKer;
          end
        end
      end
      StLdKer: begin
        ker_beat_d = 1'b1;
        if (col_q != conv_ker_col) begin
          ker_rd      = 1'b1;
          ker_addr    = {row_q, col_q};
          ker_fetch_d = 1'b1;
          col_d       = col_q + One;
        end else begin
          col_d = '0;
          row_d = row_q + One;
          if (row_q == conv_ker_row - One) begin
            row_d    = '0;
            settle_d = '0;
            state_d  = (SETTLE_CYC == 0) ? StCompute : StSettle;
          end
        end
      end
      StSettle: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SW'(SETTLE_CYC - 1)) state_d = StCompute;
      end
      StCompute: begin
        // Nest order (outer to inner): output row, output col, kernel row, kernel col + delimiter.
        l_d = l_q + One;
        if (l_q == conv_ker_col) begin
          l_d = '0;
          k_d = k_q + One;
          if (k_q == conv_ker_row - One) begin
            k_d   = '0;
            col_d = col_q + One;
            if (col_q == out_cols - One) begin
              col_d = '0;
              row_d = row_q + One;
              if (row_q == out_rows - One) begin
                row_d   = '0;
                state_d = StDrain;
              end
            end
          end
        end
      end
      StDrain: begin
        res_valid = 1'b1;
        res_data  = conv_out;
        res_row   = row_q;
        res_col   = col_q;
        col_d     = col_q + One;
        if (col_q == out_cols - One) begin
          col_d = '0;
          row_d = row_q + One;
          if (row_q == out_rows - One) begin
            row_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_conv_seq.sv
// Directed bench for conv_seq: buffer models and a behavioural conv stub around the sequencer,
// a table of job shapes with hand-computed beat counts, plus abort and stray-start sequences.
module tb_conv_seq;
  localparam int DW     = 8;
  localparam int OW     = 16;
  localparam int DIMW   = 4;
  localparam int SETTLE = 2;
  localparam int LOGN   = 1024;
  localparam int NV     = 7;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [DIMW-1:0]   in_row, in_col, ker_row, ker_col;
  logic              busy, done, cfg_err;
  logic              img_rd, ker_rd;
  logic [2*DIMW-1:0] img_addr, ker_addr;
  logic [DW-1:0]     img_rdata, ker_rdata;
  logic [DW-1:0]     conv_in_matrix, conv_kernel;
  logic [DIMW-1:0]   conv_in_row, conv_in_col, conv_ker_row, conv_ker_col;
  logic [OW-1:0]     conv_out;
  logic              res_valid;
  logic [OW-1:0]     res_data;
  logic [DIMW-1:0]   res_row, res_col;

  always #5 clk = ~clk;

  conv_seq #(.DW(DW), .OW(OW), .DIMW(DIMW), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_row(in_row), .in_col(in_col), .ker_row(ker_row), .ker_col(ker_col),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .img_rd(img_rd), .img_addr(img_addr), .img_rdata(img_rdata),
    .ker_rd(ker_rd), .ker_addr(ker_addr), .ker_rdata(ker_rdata),
    .conv_in_matrix(conv_in_matrix), .conv_kernel(conv_kernel),
    .conv_in_row(conv_in_row), .conv_in_col(conv_in_col),
    .conv_ker_row(conv_ker_row), .conv_ker_col(conv_ker_col),
    .conv_out(conv_out), .res_valid(res_valid), .res_data(res_data),
    .res_row(res_row), .res_col(res_col)
  );

  // Buffers, addressed {row,col}.
  logic [DW-1:0] img_mem [256];
  logic [DW-1:0] ker_mem [256];

  always @(posedge clk) begin
    if (img_rd) img_rdata <= img_mem[img_addr];
    if (ker_rd) ker_rdata <= ker_mem[ker_addr];
  end

  // Image: row 0 is 1,0,2,3,..., other entries r*5+c. Kernel: 1 on the even-parity cells of the
  // top-left 3x3, 0 on the odd ones, distinct values elsewhere.
  function automatic logic [DW-1:0] img_val(int r, int c);
    if (r == 0 && c == 0) return 8'd1;
    if (r == 0 && c == 1) return 8'd0;
    return DW'(r * 5 + c);
  endfunction

  function automatic logic [DW-1:0] ker_val(int k, int l);
    if (k < 3 && l < 3) return ((k + l) % 2 == 0) ? 8'd1 : 8'd0;
    return DW'(k * 16 + l + 7);
  endfunction

  int cur_kr, cur_kc;

  function automatic int conv_model(int r, int c);
    int acc = 0;
    for (int k = 0; k < cur_kr; k++)
      for (int l = 0; l < cur_kc; l++)
        if (r + k < 16 && c + l < 16)
          acc += int'(img_mem[(r + k) * 16 + c + l]) * int'(ker_mem[k * 16 + l]);
    return acc;
  endfunction

  // Stand-in for conv's result stream, indexed by the coordinates the sequencer presents.
  assign conv_out = OW'(conv_model(int'(res_row), int'(res_col)));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit outputs_zero();
    return !(busy || done || cfg_err || img_rd || ker_rd || res_valid) &&
           img_addr == '0 && ker_addr == '0 && conv_in_matrix == '0 && conv_kernel == '0 &&
           conv_in_row == '0 && conv_in_col == '0 && conv_ker_row == '0 &&
           conv_ker_col == '0 && res_data == '0 && res_row == '0 && res_col == '0;
  endfunction

  typedef struct {
    int ir, ic, kr, kc;
    bit bad;
    int img_beats, ker_beats, comp, res;
  } vec_t;

  vec_t vecs [NV];

  // Per-job observation log.
  int n_img_rd, n_ker_rd, n_rv, n_done, n_err, n_busy, n_viol, n_late_rd;
  int t_img, t_ker, t_rv, t_done;
  logic busy_at_done;
  bit rst_seen, rst_zero;
  logic [DW-1:0]   log_mat [LOGN];
  logic [DW-1:0]   log_ker [LOGN];
  logic [OW-1:0]   log_res [256];
  logic [DIMW-1:0] log_rr [256];
  logic [DIMW-1:0] log_rc [256];

  task automatic run_job(input int ir, input int ic, input int kr, input int kc, input int max_t,
                         input int stray_at, input bit stray_done, input int rst_at);
    int done_at;
    done_at = -1;
    n_img_rd = 0; n_ker_rd = 0; n_rv = 0; n_done = 0; n_err = 0; n_busy = 0;
    n_viol = 0; n_late_rd = 0;
    t_img = -1; t_ker = -1; t_rv = -1; busy_at_done = 1'bx;
    rst_seen = 1'b0; rst_zero = 1'b0;
    cur_kr = kr; cur_kc = kc;
    @(negedge clk);
    in_row = DIMW'(ir); in_col = DIMW'(ic); ker_row = DIMW'(kr); ker_col = DIMW'(kc);
    start = 1'b1;
    for (int t = 1; t <= max_t; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        rst_seen = 1'b1;
        rst_zero = outputs_zero();
      end
      if (t < LOGN) begin
        log_mat[t] = conv_in_matrix;
        log_ker[t] = conv_kernel;
      end
      if (img_rd) begin n_img_rd++; if (t_img < 0) t_img = t; end
      if (ker_rd) begin n_ker_rd++; if (t_ker < 0) t_ker = t; end
      if (img_rd && ker_rd) n_viol++;
      if ((img_rd || ker_rd) && (done_at >= 0 || rst_seen)) n_late_rd++;
      if (busy) n_busy++;
      if (res_valid) begin
        if (n_rv < 256) begin
          log_res[n_rv] = res_data; log_rr[n_rv] = res_row; log_rc[n_rv] = res_col;
        end
        if (t_rv < 0) t_rv = t;
        n_rv++;
      end else if (res_row != '0 || res_col != '0) begin
        n_viol++;
      end
      if (cfg_err) n_err++;
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = t;
          busy_at_done = busy;
          if (stray_done) begin
            start = 1'b1; in_row = 2; in_col = 2; ker_row = 1; ker_col = 1;
          end
        end
      end
      if (t == stray_at) begin
        start = 1'b1; in_row = 1; in_col = 1; ker_row = 1; ker_col = 1;
      end
      if (t == rst_at) rst = 1'b1;
      if (done_at >= 0 && t >= done_at + 4) break;
    end
    start = 1'b0;
    t_done = done_at;
  endtask

  task automatic check_job(input string tag, input vec_t v);
    int bad_mat, bad_ker, bad_res, last;
    bad_mat = 0; bad_ker = 0; bad_res = 0;
    if (v.bad) begin
      check({tag, " reject done time"}, t_done, 1);
      check({tag, " cfg_err pulses"}, n_err, 1);
      check({tag, " done pulses"}, n_done, 1);
      check({tag, " buffer reads"}, n_img_rd + n_ker_rd, 0);
      check({tag, " busy cycles"}, n_busy, 0);
      return;
    end
    last = 1 + v.img_beats + v.ker_beats + SETTLE + v.comp + v.res;
    check({tag, " first img read"}, t_img, 1);
    check({tag, " first ker read"}, t_ker, 1 + v.img_beats);
    check({tag, " first result"}, t_rv, 1 + v.img_beats + v.ker_beats + SETTLE + v.comp);
    check({tag, " result beats"}, n_rv, v.res);
    check({tag, " done time"}, t_done, last);
    check({tag, " done pulses"}, n_done, 1);
    check({tag, " cfg_err pulses"}, n_err, 0);
    check({tag, " img reads"}, n_img_rd, v.ir * v.ic);
    check({tag, " ker reads"}, n_ker_rd, v.kr * v.kc);
    check({tag, " busy cycles"}, n_busy, last - 1);
    check({tag, " busy at done"}, busy_at_done, 0);
    check({tag, " protocol violations"}, n_viol + n_late_rd, 0);
    for (int b = 0; b < v.img_beats; b++) begin
      int r, c;
      r = b / (v.ic + 1); c = b % (v.ic + 1);
      if (log_mat[b + 3] !== ((c == v.ic) ? 8'd0 : img_mem[r * 16 + c])) bad_mat++;
    end
    for (int b = 0; b < v.ker_beats; b++) begin
      int r, c;
      r = b / (v.kc + 1); c = b % (v.kc + 1);
      if (log_ker[v.img_beats + b + 3] !== ((c == v.kc) ? 8'd0 : ker_mem[r * 16 + c])) bad_ker++;
    end
    for (int b = 0; b < v.res && b < 256; b++) begin
      int oc, i, j;
      oc = v.ic - v.kc + 1; i = b / oc; j = b % oc;
      if (log_rr[b] !== DIMW'(i) || log_rc[b] !== DIMW'(j) ||
          log_res[b] !== OW'(conv_model(i, j))) bad_res++;
    end
    check({tag, " matrix beat errors"}, bad_mat, 0);
    check({tag, " kernel beat errors"}, bad_ker, 0);
    check({tag, " result beat errors"}, bad_res, 0);
  endtask

  initial begin
    vecs[0] = '{5, 5, 3, 3, 1'b0, 30, 12, 108, 9};
    vecs[1] = '{3, 3, 4, 1, 1'b1, 0, 0, 0, 0};
    vecs[2] = '{1, 1, 1, 1, 1'b0, 2, 2, 2, 1};
    vecs[3] = '{15, 15, 1, 1, 1'b0, 240, 2, 450, 225};
    vecs[4] = '{4, 6, 2, 3, 1'b0, 28, 8, 96, 12};
    vecs[5] = '{3, 3, 0, 1, 1'b1, 0, 0, 0, 0};
    vecs[6] = '{2, 2, 2, 3, 1'b1, 0, 0, 0, 0};
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        img_mem[r * 16 + c] = img_val(r, c);
        ker_mem[r * 16 + c] = ker_val(r, c);
      end

    rst = 1'b1; start = 1'b0;
    in_row = '0; in_col = '0; ker_row = '0; ker_col = '0;
    repeat (3) @(negedge clk);
    check("reset outputs zero", outputs_zero(), 1);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_job(vecs[i].ir, vecs[i].ic, vecs[i].kr, vecs[i].kc, 1000, -1, 1'b0, -1);
      check_job($sformatf("vec%0d", i), vecs[i]);
    end

    // Known results of the 5x5 image against the corners-and-centre kernel.
    run_job(5, 5, 3, 3, 1000, -1, 1'b0, -1);
    check("res(0,0) value", log_res[0], 31);
    check("res(0,1) value", log_res[1], 34);
    check("row delimiter beat 6", log_mat[8], 0);

    // Stray starts during kernel load and in the done cycle.
    run_job(5, 5, 3, 3, 1000, 35, 1'b1, -1);
    check_job("stray", vecs[0]);
    check("stray latched in_row", conv_in_row, 5);
    check("stray latched ker_row", conv_ker_row, 3);

    // Reset in the middle of compute, then a clean job.
    run_job(5, 5, 3, 3, 80, -1, 1'b0, 60);
    check("abort outputs zero", rst_zero, 1);
    check("abort done pulses", n_done, 0);
    check("abort late reads", n_late_rd, 0);
    check("abort busy cycles", n_busy, 60);
    run_job(5, 5, 3, 3, 1000, -1, 1'b0, -1);
    check_job("after abort", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
